// File: rtl/ucode_sequencer.sv
// ucode_sequencer: per-opcode micro-step walker with stall, conditional exit, HALT/wake and IRQ dispatch
//
// Ports:
//   clk, rst                      core clock, asynchronous active-high reset
//   seq_table                     MAX_STEPS packed STATE_W step codes, entry 0 in the LSBs
//   last_idx                      final step of the current op (clamped to MAX_STEPS-1)
//   cond_en, cond_exit_idx,
//   cond_fail                     conditional early exit of branch-type ops
//   stall                         memory wait state, freezes RUN and IRQ sequencing
//   ime, irq_pending              interrupt master enable and request
//   cur_state, cur_idx            active micro-step code and index
//   step_valid, fetch             act on cur_state / load IR and bump PC
//   irq_mode, irq_step, irq_ack   interrupt dispatch status
//   halted                        core in HALT
//   instr_count, stall_count      performance counters, present only with UCODE_PERF_CNT_EN
//
// Build option: define UCODE_PERF_CNT_EN to synthesise the performance counters;
// otherwise both counter ports read 0.
module ucode_sequencer #(
    parameter int                 MAX_STEPS  = 8,
    parameter int                 STATE_W    = 5,
    parameter logic [STATE_W-1:0] HALT_STATE = 'h1E,
    parameter int                 IRQ_CYCLES = 5,
    localparam int                IDX_W      = $clog2(MAX_STEPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MAX_STEPS*STATE_W-1:0] seq_table,
    input  logic [IDX_W-1:0]             last_idx,
    input  logic                         cond_en,
    input  logic [IDX_W-1:0]             cond_exit_idx,
    input  logic                         cond_fail,
    input  logic                         stall,
    input  logic                         ime,
    input  logic                         irq_pending,
    output logic [STATE_W-1:0]           cur_state,
    output logic [IDX_W-1:0]             cur_idx,
    output logic                         step_valid,
    output logic                         fetch,
    output logic                         irq_mode,
    output logic [2:0]                   irq_step,
    output logic                         irq_ack,
    output logic                         halted,
    output logic [31:0]                  instr_count,
    output logic [15:0]                  stall_count
);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(MAX_STEPS - 1);
    localparam logic [2:0]       IRQ_LAST = 3'(IRQ_CYCLES - 1);

    typedef enum logic [1:0] {RUN, HALTED, IRQ} state_t;
    state_t st;

    logic [STATE_W-1:0] tbl [MAX_STEPS];
    logic [IDX_W-1:0]   last_eff;
    logic               irq_req, end_op, halt_hit, irq_last;

    for (genvar g = 0; g < MAX_STEPS; g++) begin : g_tbl
        assign tbl[g] = seq_table[g*STATE_W +: STATE_W];
    end

    // Outputs are combinational on the registered state so stall and
    // condition inputs act in the same cycle; rst masks the strobes.
    assign last_eff   = (last_idx > IDX_MAX) ? IDX_MAX : last_idx;
    assign irq_req    = ime && irq_pending;
    assign cur_state  = (st == RUN) ? tbl[cur_idx] : '0;
    assign step_valid = !rst && st != HALTED && !stall;
    assign end_op     = step_valid && st == RUN &&
                        (cur_idx >= last_eff || (cond_en && cond_fail && cur_idx == cond_exit_idx));
    assign halt_hit   = step_valid && st == RUN && cur_state == HALT_STATE;
    assign irq_last   = step_valid && st == IRQ && irq_step == IRQ_LAST;
    assign irq_ack    = irq_last;
    // HALT outranks end_op, so a HALT step on the last index never fetches.
    assign fetch      = (end_op && !halt_hit && !irq_req) || irq_last ||
                        (!rst && st == HALTED && irq_pending && !ime);
    assign halted     = st == HALTED;
    assign irq_mode   = st == IRQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= RUN;
            cur_idx  <= '0;
            irq_step <= '0;
        end else begin
            case (st)
                RUN: begin
                    if (halt_hit) begin
                        st      <= HALTED;
                        cur_idx <= '0;
                    end else if (end_op) begin
                        cur_idx  <= '0;
                        irq_step <= '0;
                        if (irq_req) st <= IRQ;
                    end else if (step_valid) begin
                        cur_idx <= cur_idx + 1'b1;
                    end
                end
                HALTED: begin
                    if (irq_pending) begin
                        st       <= ime ? IRQ : RUN;
                        cur_idx  <= '0;
                        irq_step <= '0;
                    end
                end
                IRQ: begin
                    if (irq_last) begin
                        st       <= RUN;
                        cur_idx  <= '0;
                        irq_step <= '0;
                    end else if (step_valid) begin
                        irq_step <= irq_step + 1'b1;
                    end
                end
                default: st <= RUN;
            endcase
        end
    end

`ifdef UCODE_PERF_CNT_EN
    logic [31:0] ic;
    logic [15:0] sc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ic <= '0;
            sc <= '0;
        end else begin
            if (fetch) ic <= ic + 1'b1;
            // HALTED ignores stall, so only RUN/IRQ wait states are counted.
            if (stall && st != HALTED && sc != 16'hFFFF) sc <= sc + 1'b1;
        end
    end

    assign instr_count = ic;
    assign stall_count = sc;
`else
    assign instr_count = '0;
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: directed self-checking bench for ucode_sequencer
module tb_ucode_sequencer;
    logic        clk, rst;
    logic [39:0] seq_table;
    logic [2:0]  last_idx, cond_exit_idx, cur_idx, irq_step;
    logic        cond_en, cond_fail, stall, ime, irq_pending;
    logic [4:0]  cur_state;
    logic        step_valid, fetch, irq_mode, irq_ack, halted;
    logic [31:0] instr_count;
    logic [15:0] stall_count;
    int          checks = 0;
    int          errors = 0;

    ucode_sequencer dut (
        .clk(clk), .rst(rst), .seq_table(seq_table), .last_idx(last_idx),
        .cond_en(cond_en), .cond_exit_idx(cond_exit_idx), .cond_fail(cond_fail),
        .stall(stall), .ime(ime), .irq_pending(irq_pending),
        .cur_state(cur_state), .cur_idx(cur_idx), .step_valid(step_valid),
        .fetch(fetch), .irq_mode(irq_mode), .irq_step(irq_step), .irq_ack(irq_ack),
        .halted(halted), .instr_count(instr_count), .stall_count(stall_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check one RUN cycle, then advance past the next edge.
    task automatic step(input string tag, input int st, input int idx, input bit sv, input bit fe);
        #1;
        chk({tag, ".state"}, 32'(cur_state), st);
        chk({tag, ".idx"}, 32'(cur_idx), idx);
        chk({tag, ".valid"}, 32'(step_valid), 32'(sv));
        chk({tag, ".fetch"}, 32'(fetch), 32'(fe));
        tick();
    endtask

    initial begin
        rst = 1; stall = 0; ime = 0; irq_pending = 0;
        cond_en = 0; cond_fail = 0; cond_exit_idx = 0; last_idx = 3;
        seq_table = {5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd3, 5'd2, 5'd1};
        #2;
        chk("rst.state", 32'(cur_state), 1);
        chk("rst.valid", 32'(step_valid), 0);
        chk("rst.fetch", 32'(fetch), 0);
        chk("rst.idx", 32'(cur_idx), 0);
        chk("rst.halted", 32'(halted), 0);
        chk("rst.irq", 32'(irq_mode), 0);
        chk("rst.ic", instr_count, 0);
        tick();
        rst = 0;

        step("a0", 1, 0, 1, 0);
        step("a1", 2, 1, 1, 0);
        step("a2", 3, 2, 1, 0);
        step("a3", 4, 3, 1, 1);

        step("b0", 1, 0, 1, 0);
        stall = 1;
        step("b1", 2, 1, 0, 0);
        step("b2", 2, 1, 0, 0);
        stall = 0;
        step("b3", 2, 1, 1, 0);
        step("b4", 3, 2, 1, 0);
        step("b5", 4, 3, 1, 1);

        seq_table = {5'd0, 5'd0, 5'd0, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
        last_idx = 4; cond_en = 1; cond_exit_idx = 1; cond_fail = 1;
        step("c0", 1, 0, 1, 0);
        step("c1", 2, 1, 1, 1);
        cond_en = 0;
        step("d0", 1, 0, 1, 0);
        step("d1", 2, 1, 1, 0);
        step("d2", 3, 2, 1, 0);
        step("d3", 4, 3, 1, 0);
        step("d4", 5, 4, 1, 1);
        cond_fail = 0;

        last_idx = 0;
        step("z0", 1, 0, 1, 1);
        step("z1", 1, 0, 1, 1);

        seq_table = {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'h1E, 5'd1};
        last_idx = 1;
        step("h0", 1, 0, 1, 0);
        step("h1", 30, 1, 1, 0);
        stall = 1;
        #1;
        chk("hs.halted", 32'(halted), 1);
        chk("hs.state", 32'(cur_state), 0);
        chk("hs.valid", 32'(step_valid), 0);
        chk("hs.fetch", 32'(fetch), 0);
        tick();
        stall = 0; irq_pending = 1;
        #1;
        chk("hw.fetch", 32'(fetch), 1);
        chk("hw.halted", 32'(halted), 1);
        tick();
        irq_pending = 0;
        #1;
        chk("hw.run", 32'(halted), 0);
        step("h2", 1, 0, 1, 0);
        step("h3", 30, 1, 1, 0);
        ime = 1; irq_pending = 1;
        #1;
        chk("hi.halted", 32'(halted), 1);
        chk("hi.fetch", 32'(fetch), 0);
        tick();
        irq_pending = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                stall = 1;
                #1;
                chk("is.valid", 32'(step_valid), 0);
                chk("is.ack", 32'(irq_ack), 0);
                tick();
                stall = 0;
            end
            #1;
            chk("i.mode", 32'(irq_mode), 1);
            chk("i.step", 32'(irq_step), 32'(k));
            chk("i.state", 32'(cur_state), 0);
            chk("i.ack", 32'(irq_ack), 32'(k == 4));
            chk("i.fetch", 32'(fetch), 32'(k == 4));
            tick();
        end
        #1;
        chk("ie.mode", 32'(irq_mode), 0);
        chk("ie.idx", 32'(cur_idx), 0);
        chk("ie.halted", 32'(halted), 0);

        seq_table = {5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd3, 5'd2, 5'd1};
        irq_pending = 1;
        step("e0", 1, 0, 1, 0);
        step("e1", 2, 1, 1, 0);
        #1;
        chk("e.mode", 32'(irq_mode), 1);
        chk("e.step0", 32'(irq_step), 0);
        tick();
        tick();
        #1;
        chk("e.step2", 32'(irq_step), 2);
`ifdef UCODE_PERF_CNT_EN
        chk("p.stalls", 32'(stall_count), 3);
`endif
        rst = 1;
        #1;
        chk("r.mode", 32'(irq_mode), 0);
        chk("r.idx", 32'(cur_idx), 0);
        chk("r.step", 32'(irq_step), 0);
        chk("r.halted", 32'(halted), 0);
        chk("r.fetch", 32'(fetch), 0);
        chk("r.ic", instr_count, 0);
        chk("r.sc", 32'(stall_count), 0);
        tick();
        rst = 0; irq_pending = 0; ime = 0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
